// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit. Takes the EX ALU result as the effective address,
//   checks alignment, and drives a single-outstanding SRAM-like data bus. Load data
//   is extended and latched, and the pipeline is stalled until the access completes.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   mem_enM, mem_opM      valid memory op in MEM and its opcode (LB..SW)
//   addrM, wdataM         effective address and raw store data
//   flushM, stallW        kill current MEM op / downstream stall
//   data_req/wr/size/addr/wdata   bus request channel
//   data_addr_ok/data_ok/rdata    bus handshake and read data
//   rdataM                extended load result (valid in DONE)
//   mem_stallM            freeze IF..MEM
//   adelM/adesM/bad_addrM load/store address error and faulting address
module mem_access_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic [2:0]  mem_opM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        flushM,
  input  logic        stallW,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdataM,
  output logic        mem_stallM,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] bad_addrM
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLbu = 3'b001;
  localparam logic [2:0] OpLh  = 3'b010;
  localparam logic [2:0] OpLhu = 3'b011;
  localparam logic [2:0] OpLw  = 3'b100;
  localparam logic [2:0] OpSb  = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;

  // 0 byte, 1 half, 2 word
  function automatic logic [1:0] op_size(input logic [2:0] op);
    logic [1:0] sz;
    sz = 2'd2;
    if (op == OpLb || op == OpLbu || op == OpSb) sz = 2'd0;
    if (op == OpLh || op == OpLhu || op == OpSh) sz = 2'd1;
    return sz;
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return op > OpLw;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  live_size;
  logic        live_wr;
  logic [31:0] live_wdata;
  logic        misalign;
  logic        err;
  logic        start;
  logic [31:0] shifted_rdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode of the live MEM-stage instruction
  always_comb begin
    live_size  = op_size(mem_opM);
    live_wr    = op_is_store(mem_opM);
    live_wdata = wdataM;
    misalign   = 1'b0;
    unique case (live_size)
      2'd0: live_wdata = {4{wdataM[7:0]}};
      2'd1: begin
        live_wdata = {2{wdataM[15:0]}};
        misalign   = addrM[0];
      end
      default: misalign = |addrM[1:0];
    endcase
  end

  assign err       = CHECK_ALIGN & misalign;
  assign adelM     = mem_enM & err & ~live_wr;
  assign adesM     = mem_enM & err & live_wr;
  assign bad_addrM = (adelM | adesM) ? addrM : 32'h0;
  assign start     = mem_enM & ~err & ~flushM;

  // Lane select uses the address captured at issue; addrM may already have moved.
  always_comb begin
    shifted_rdata = data_rdata >> {addr_q[1:0], 3'b000};
    ld_byte       = shifted_rdata[7:0];
    ld_half       = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    unique case (op_q)
      OpLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   ld_ext = {24'h0, ld_byte};
      OpLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
      OpLhu:   ld_ext = {16'h0, ld_half};
      OpLw:    ld_ext = data_rdata;
      default: ld_ext = 32'h0;  // stores return no data
    endcase
  end

  // Bus fields come straight from the pipeline in the issue cycle, from the
  // captured copies afterwards so they stay stable while addr_ok is pending.
  always_comb begin
    if (state_q == StIdle) begin
      data_wr    = live_wr;
      data_size  = live_size;
      data_addr  = addrM;
      data_wdata = live_wdata;
    end else begin
      data_wr    = op_is_store(op_q);
      data_size  = op_size(op_q);
      data_addr  = addr_q;
      data_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    data_req   = 1'b0;
    mem_stallM = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_req   = 1'b1;
          mem_stallM = 1'b1;
          addr_d     = addrM;
          op_d       = mem_opM;
          wdata_d    = live_wdata;
          state_d    = data_addr_ok ? StWait : StReq;
        end
      end
      StReq: begin
        data_req   = 1'b1;
        mem_stallM = 1'b1;
        if (data_addr_ok) begin
          // Accepted in the same cycle as a flush: the response must still be absorbed.
          state_d = flushM ? StDrain : StWait;
        end else if (flushM) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        mem_stallM = 1'b1;
        if (data_data_ok) begin
          if (flushM) begin
            state_d = StIdle;
          end else begin
            rdata_d = ld_ext;
            state_d = StDone;
          end
        end else if (flushM) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        if (flushM || !stallW) state_d = StIdle;
      end
      StDrain: begin
        // Flushed op is gone; a new op in MEM must wait for the orphan response.
        mem_stallM = mem_enM;
        if (data_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      op_q    <= 3'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdataM = rdata_q;

endmodule
